// File: rtl/iir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iir_stream_ctrl
// Purpose  : Run sequencer for the 5th-order IIR stream: clear, stream, drain.
// Revision : 1.0  initial release
// ============================================================================
module iir_stream_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int CLR_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic              data_done,
    input  logic              stall,
    output logic              filt_clr,
    output logic              filt_en,
    output logic              load,
    output logic [ADDR_W-1:0] RAddr,
    output logic              WEN,
    output logic [ADDR_W-1:0] WAddr,
    output logic              busy,
    output logic              Finish,
    output logic [ADDR_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]        c_CLR_LAST = 4'(CLR_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_len, w_len;
    logic [ADDR_W-1:0] r_raddr, w_raddr;
    logic [ADDR_W-1:0] r_waddr, w_waddr;
    logic [ADDR_W-1:0] r_cnt, w_cnt;
    logic [3:0]        r_clr, w_clr;
    logic              r_load, w_load;
    logic              r_wen, w_wen;
    logic              r_fin, w_fin;
    logic              r_busy, w_busy;
    logic              r_filt_clr, w_filt_clr;
    logic              w_last;

    // Outputs are registered, so stall sampled at an edge gates the read shown
    // in the following cycle; data_done qualifies the read currently shown.
    always_comb begin
        w_state = r_state;
        w_len   = r_len;
        w_raddr = r_raddr;
        w_waddr = r_waddr;
        w_cnt   = r_cnt + {{(ADDR_W-1){1'b0}}, r_wen};
        w_clr   = r_clr;
        w_load  = 1'b0;
        w_wen   = 1'b0;
        w_fin   = r_fin;
        w_last  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state = S_CLEAR;
                    w_len   = num_samples;
                    w_raddr = '0;
                    w_waddr = '0;
                    w_cnt   = '0;
                    w_clr   = c_CLR_LAST;
                    w_fin   = 1'b0;
                end
            end
            S_CLEAR: begin
                if (r_clr != 4'd0) begin
                    w_clr = r_clr - 4'd1;
                end else if (r_len == '0) begin
                    w_state = S_DONE;
                    w_fin   = 1'b1;
                end else begin
                    w_state = S_RUN;
                    w_load  = !stall;
                end
            end
            S_RUN: begin
                w_wen = r_load;
                if (r_load) begin
                    w_waddr = r_raddr;
                end
                // Last-read test happens before the increment, so RAddr never wraps.
                w_last = data_done || (r_load && (r_raddr == r_len - c_ONE));
                if (w_last) begin
                    w_state = S_DRAIN;
                end else begin
                    if (r_load) begin
                        w_raddr = r_raddr + c_ONE;
                    end
                    w_load = !stall;
                end
            end
            S_DRAIN: begin
                w_state = S_DONE;
                w_fin   = 1'b1;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy     = (w_state == S_CLEAR) || (w_state == S_RUN) || (w_state == S_DRAIN);
        w_filt_clr = (w_state == S_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_cnt      <= '0;
            r_clr      <= 4'd0;
            r_load     <= 1'b0;
            r_wen      <= 1'b0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_filt_clr <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_len      <= w_len;
            r_raddr    <= w_raddr;
            r_waddr    <= w_waddr;
            r_cnt      <= w_cnt;
            r_clr      <= w_clr;
            r_load     <= w_load;
            r_wen      <= w_wen;
            r_fin      <= w_fin;
            r_busy     <= w_busy;
            r_filt_clr <= w_filt_clr;
        end
    end

    assign filt_clr   = r_filt_clr;
    assign filt_en    = r_load;
    assign load       = r_load;
    assign RAddr      = r_raddr;
    assign WEN        = r_wen;
    assign WAddr      = r_waddr;
    assign busy       = r_busy;
    assign Finish     = r_fin;
    assign sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_stream_ctrl
// Purpose  : Bench for iir_stream_ctrl, CLR_CYCLES=1 and CLR_CYCLES=3 side by side.
// Revision : 1.0  initial release
// ============================================================================
module tb_iir_stream_ctrl;
    localparam int AW = 8;
    localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_DRN = 3, P_DONE = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, data_done = 1'b0, stall = 1'b0;
    logic [AW-1:0] num_samples = '0;

    logic d0_filt_clr, d0_filt_en, d0_load, d0_WEN, d0_busy, d0_Finish;
    logic [AW-1:0] d0_RAddr, d0_WAddr, d0_sample_cnt;
    logic d1_filt_clr, d1_filt_en, d1_load, d1_WEN, d1_busy, d1_Finish;
    logic [AW-1:0] d1_RAddr, d1_WAddr, d1_sample_cnt;

    iir_stream_ctrl #(.ADDR_W(AW), .CLR_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .data_done(data_done), .stall(stall), .filt_clr(d0_filt_clr),
        .filt_en(d0_filt_en), .load(d0_load), .RAddr(d0_RAddr), .WEN(d0_WEN),
        .WAddr(d0_WAddr), .busy(d0_busy), .Finish(d0_Finish), .sample_cnt(d0_sample_cnt)
    );

    iir_stream_ctrl #(.ADDR_W(AW), .CLR_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .data_done(data_done), .stall(stall), .filt_clr(d1_filt_clr),
        .filt_en(d1_filt_en), .load(d1_load), .RAddr(d1_RAddr), .WEN(d1_WEN),
        .WAddr(d1_WAddr), .busy(d1_busy), .Finish(d1_Finish), .sample_cnt(d1_sample_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;

    // Reference model: one run phase per instance plus the read shown / write shown.
    int m_ph[2], m_len[2], m_clr[2], m_ra[2], m_ld[2], m_we[2], m_wa[2], m_cnt[2], m_fin[2];
    int clrn[2];

    // Per-run observations of the DUT for spec-level checks.
    int n_ld0, n_clr0, n_clr1, max_ra0, first1, first_ld0, first_we0, last_we0, fin_cyc0;
    logic [AW-1:0] wlog0[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_IDLE; m_len[k] = 0; m_clr[k] = 0; m_ra[k] = 0; m_ld[k] = 0;
            m_we[k] = 0; m_wa[k] = 0; m_cnt[k] = 0; m_fin[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int nwe, nld;
        nwe = 0;
        nld = 0;
        m_cnt[k] += m_we[k];
        case (m_ph[k])
            P_IDLE, P_DONE: if (start) begin
                m_ph[k] = P_CLR; m_len[k] = int'(num_samples); m_clr[k] = clrn[k];
                m_ra[k] = 0; m_wa[k] = 0; m_cnt[k] = 0; m_fin[k] = 0;
            end
            P_CLR: begin
                m_clr[k]--;
                if (m_clr[k] == 0) begin
                    if (m_len[k] == 0) begin m_ph[k] = P_DONE; m_fin[k] = 1; end
                    else begin m_ph[k] = P_RUN; nld = !stall; end
                end
            end
            P_RUN: begin
                if (m_ld[k] != 0) begin nwe = 1; m_wa[k] = m_ra[k]; end
                if (data_done || (m_ld[k] != 0 && m_ra[k] == m_len[k] - 1)) m_ph[k] = P_DRN;
                else begin
                    if (m_ld[k] != 0) m_ra[k]++;
                    nld = !stall;
                end
            end
            P_DRN: begin m_ph[k] = P_DONE; m_fin[k] = 1; end
            default: m_ph[k] = P_IDLE;
        endcase
        m_ld[k] = nld;
        m_we[k] = nwe;
    endtask

    task automatic check_inst(input int k, input logic fc, input logic fe, input logic ld,
                              input logic we, input logic bz, input logic fn,
                              input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                              input logic [AW-1:0] cn);
        string p;
        p = (k == 0) ? "u0" : "u1";
        chk({p, " filt_clr"}, fc, m_ph[k] == P_CLR);
        chk({p, " filt_en"}, fe, m_ld[k]);
        chk({p, " load"}, ld, m_ld[k]);
        chk({p, " WEN"}, we, m_we[k]);
        chk({p, " busy"}, bz, m_ph[k] == P_CLR || m_ph[k] == P_RUN || m_ph[k] == P_DRN);
        chk({p, " Finish"}, fn, m_fin[k]);
        chk({p, " RAddr"}, ra, m_ra[k]);
        chk({p, " WAddr"}, wa, m_wa[k]);
        chk({p, " sample_cnt"}, cn, m_cnt[k]);
    endtask

    task automatic check_all();
        check_inst(0, d0_filt_clr, d0_filt_en, d0_load, d0_WEN, d0_busy, d0_Finish,
                   d0_RAddr, d0_WAddr, d0_sample_cnt);
        check_inst(1, d1_filt_clr, d1_filt_en, d1_load, d1_WEN, d1_busy, d1_Finish,
                   d1_RAddr, d1_WAddr, d1_sample_cnt);
        if (d0_filt_clr) n_clr0++;
        if (d1_filt_clr) n_clr1++;
        if (d0_load) begin
            n_ld0++;
            if (int'(d0_RAddr) > max_ra0) max_ra0 = int'(d0_RAddr);
            if (first_ld0 < 0) first_ld0 = cyc;
        end
        if (d0_WEN) begin
            wlog0.push_back(d0_WAddr);
            if (first_we0 < 0) first_we0 = cyc;
            last_we0 = cyc;
        end
        if (d0_Finish && fin_cyc0 < 0) fin_cyc0 = cyc;
        if (d1_load && first1 < 0) first1 = int'(d1_RAddr);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_logs();
        n_ld0 = 0; n_clr0 = 0; n_clr1 = 0; max_ra0 = -1; first1 = -1;
        first_ld0 = -1; first_we0 = -1; last_we0 = -1; fin_cyc0 = -1;
        wlog0.delete();
    endtask

    // mode: 0 clean, 1 stall on edges 3..5, 2 data_done on edge 6, 3 random
    task automatic run(input int num, input int mode, input bit hold_start);
        bit done;
        done = 1'b0;
        clear_logs();
        start = 1'b1; num_samples = AW'(num); stall = 1'b0; data_done = 1'b0;
        cycle();
        if (!hold_start) start = 1'b0;
        for (int i = 1; i <= 3000 && !done; i++) begin
            case (mode)
                1: stall = (i >= 3 && i <= 5);
                2: data_done = (i == 6);
                3: begin
                    stall = ($urandom_range(0, 3) == 0);
                    data_done = ($urandom_range(0, 49) == 0);
                    num_samples = AW'($urandom);
                    start = (m_ph[0] >= P_CLR && m_ph[0] <= P_DRN &&
                             m_ph[1] >= P_CLR && m_ph[1] <= P_DRN) ? ($urandom_range(0, 2) == 0) : 1'b0;
                end
                default: ;
            endcase
            if (hold_start && m_ph[0] == P_DRN) start = 1'b0;
            cycle();
            if (mode == 1 && i >= 3 && i <= 5) begin
                chk("stall RAddr hold", d0_RAddr, 2);
                chk("stall filt_en", d0_filt_en, 0);
            end
            if (mode == 1 && i >= 4 && i <= 6) chk("post-stall WEN", d0_WEN, 0);
            done = (m_ph[0] == P_DONE && m_ph[1] == P_DONE);
        end
        start = 1'b0; stall = 1'b0; data_done = 1'b0;
        chk("run completes", done, 1);
    endtask

    initial begin
        clrn[0] = 1;
        clrn[1] = 3;
        model_reset();
        clear_logs();
        #1;
        check_all();
        cycle();
        cycle();
        rst = 1'b0;

        // Clean run of 8 samples.
        run(8, 0, 1'b0);
        chk("t1 clear cycles", n_clr0, 1);
        chk("t1 loads", n_ld0, 8);
        chk("t1 writes", wlog0.size(), 8);
        for (int j = 0; j < 8 && j < wlog0.size(); j++) chk("t1 WAddr seq", wlog0[j], j);
        chk("t1 write latency", first_we0 - first_ld0, 1);
        chk("t1 Finish after last write", fin_cyc0 - last_we0, 1);
        chk("t1 sample_cnt", d0_sample_cnt, 8);

        // Three-cycle stall at RAddr=2.
        run(6, 1, 1'b0);
        chk("t2 writes", wlog0.size(), 6);
        for (int j = 0; j < 6 && j < wlog0.size(); j++) chk("t2 WAddr seq", wlog0[j], j);

        // data_done on the read of address 4.
        run(100, 2, 1'b0);
        chk("t3 writes", wlog0.size(), 5);
        if (wlog0.size() > 0) chk("t3 last WAddr", wlog0[wlog0.size()-1], 4);
        chk("t3 max read addr", max_ra0, 4);
        chk("t3 sample_cnt", d0_sample_cnt, 5);
        chk("t3 Finish", d0_Finish, 1);

        // Zero-length run.
        run(0, 0, 1'b0);
        chk("t4 loads", n_ld0, 0);
        chk("t4 writes", wlog0.size(), 0);
        chk("t4 clear cycles", n_clr0, 1);
        chk("t4 Finish", d0_Finish, 1);
        chk("t4 sample_cnt", d0_sample_cnt, 0);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; num_samples = AW'(10);
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && !(m_ra[0] == 3 && m_ld[0] != 0); i++) cycle();
        chk("t5 reached RAddr 3", d0_RAddr, 3);
        #1 rst = 1'b1;
        #1 model_reset();
        check_inst(0, d0_filt_clr, d0_filt_en, d0_load, d0_WEN, d0_busy, d0_Finish,
                   d0_RAddr, d0_WAddr, d0_sample_cnt);
        check_inst(1, d1_filt_clr, d1_filt_en, d1_load, d1_WEN, d1_busy, d1_Finish,
                   d1_RAddr, d1_WAddr, d1_sample_cnt);
        #1 rst = 1'b0;
        run(2, 0, 1'b0);
        chk("t5 writes after reset", wlog0.size(), 2);
        for (int j = 0; j < 2 && j < wlog0.size(); j++) chk("t5 WAddr seq", wlog0[j], j);

        // Start held high through a run, then a restart from DONE.
        run(5, 0, 1'b1);
        chk("t6 first run writes", wlog0.size(), 5);
        chk("t6 first run sample_cnt", d0_sample_cnt, 5);
        run(4, 0, 1'b0);
        chk("t6 u1 clear cycles", n_clr1, 3);
        chk("t6 u1 restart RAddr", first1, 0);
        chk("t6 u0 clear cycles", n_clr0, 1);

        // Full-range length: no address wrap.
        run((1 << AW) - 1, 0, 1'b0);
        chk("t7 loads", n_ld0, (1 << AW) - 1);
        chk("t7 max read addr", max_ra0, (1 << AW) - 2);
        chk("t7 sample_cnt", d0_sample_cnt, (1 << AW) - 1);

        // Randomized runs against the model.
        for (int r = 0; r < 25; r++) begin
            run(($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 30), 3, 1'b0);
            chk("rand cnt equals writes", d0_sample_cnt, wlog0.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
